// File: rtl/spt_pkg.sv
// Shared types and default constants for the scan period tracker.
package spt_pkg;

    // Per-channel tracking state
    typedef enum logic [1:0] {
        CH_EMPTY   = 2'd0,
        CH_ACQUIRE = 2'd1,
        CH_TRACK   = 2'd2,
        CH_LOCK    = 2'd3
    } ch_state_e;

    localparam int SPT_CNT_W       = 32;
    localparam int SPT_NUM_DIR     = 2;
    localparam int SPT_THRESHOLD   = 5000;
    localparam int SPT_ALPHA_SHIFT = 4;
    localparam int SPT_LOCK_COUNT  = 8;
    localparam int SPT_TIMEOUT     = 2**24;

    // Width of the direction select; a single channel still gets one bit.
    function automatic int spt_dir_w(input int num_dir);
        return (num_dir > 1) ? $clog2(num_dir) : 1;
    endfunction

endpackage

// File: rtl/spt_channel.sv
// One tracked scan direction: holds the smoothed period estimate, the
// acquisition state and the consecutive in-window counter used for lock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// CH_EMPTY   | no measurement since reset/timeout, estimate not valid
// CH_ACQUIRE | estimate was just (re)loaded from a raw measurement
// CH_TRACK   | in-window measurements are being smoothed in
// CH_LOCK    | LOCK_COUNT consecutive in-window measurements seen
module spt_channel
    import spt_pkg::*;
#(
    parameter int CNT_W       = SPT_CNT_W,
    parameter int THRESHOLD   = SPT_THRESHOLD,
    parameter int ALPHA_SHIFT = SPT_ALPHA_SHIFT,
    parameter int LOCK_COUNT  = SPT_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_upd,
    input  logic [CNT_W-1:0] i_meas,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_est,
    output logic             o_valid,
    output logic             o_locked
);

    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0] THRESH_C = (CNT_W+1)'(THRESHOLD);
    localparam logic [LC_W-1:0] LOCK_C  = LC_W'(LOCK_COUNT);

    ch_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_est, w_est_nxt;
    logic [LC_W-1:0]    r_lock_cnt, w_lock_cnt_nxt;

    logic signed [CNT_W:0] w_diff;
    logic signed [CNT_W:0] w_step_raw;
    logic signed [CNT_W:0] w_step;
    logic [CNT_W:0]        w_abs;
    logic                  w_in_window;

    // Signed distance from estimate, with a one-LSB floor so small errors still pull
    always_comb begin
        w_diff     = $signed({1'b0, i_meas}) - $signed({1'b0, r_est});
        w_abs      = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        w_step_raw = w_diff >>> ALPHA_SHIFT;
        w_step     = w_step_raw;
        if ((w_step_raw == '0) && (w_diff != '0)) begin
            w_step = w_diff[CNT_W] ? '1 : (CNT_W+1)'(1);
        end
        w_in_window = (w_abs <= THRESH_C);
    end

    // Next-state, estimate and lock counter
    always_comb begin
        w_state_nxt    = r_state;
        w_est_nxt      = r_est;
        w_lock_cnt_nxt = r_lock_cnt;
        if (i_clear) begin
            // estimate is deliberately kept so the last value stays observable
            w_state_nxt    = CH_EMPTY;
            w_lock_cnt_nxt = '0;
        end else if (i_upd) begin
            if ((r_state == CH_EMPTY) || !w_in_window) begin
                w_state_nxt    = CH_ACQUIRE;
                w_est_nxt      = i_meas;
                w_lock_cnt_nxt = '0;
            end else begin
                w_est_nxt = r_est + w_step[CNT_W-1:0];
                if (r_lock_cnt != LOCK_C) begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end
                w_state_nxt = (w_lock_cnt_nxt == LOCK_C) ? CH_LOCK : CH_TRACK;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= CH_EMPTY;
            r_est      <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_est      <= w_est_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign o_est    = r_est;
    assign o_valid  = (r_state != CH_EMPTY);
    assign o_locked = (r_state == CH_LOCK);

endmodule

// File: rtl/scan_period_tracker.sv
// Measures the interval between scanner sync edges and steers each
// measurement to the per-direction tracker selected by dir_in.
module scan_period_tracker
    import spt_pkg::*;
#(
    parameter int CNT_W       = SPT_CNT_W,
    parameter int NUM_DIR     = SPT_NUM_DIR,
    parameter int THRESHOLD   = SPT_THRESHOLD,
    parameter int ALPHA_SHIFT = SPT_ALPHA_SHIFT,
    parameter int LOCK_COUNT  = SPT_LOCK_COUNT,
    parameter int TIMEOUT     = SPT_TIMEOUT,
    localparam int DIR_W      = spt_dir_w(NUM_DIR)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_in,
    input  logic [DIR_W-1:0]         dir_in,
    output logic [NUM_DIR*CNT_W-1:0] est_out,
    output logic [NUM_DIR-1:0]       est_valid,
    output logic [NUM_DIR-1:0]       locked,
    output logic                     meas_strobe,
    output logic [CNT_W-1:0]         meas_out,
    output logic                     timeout_flag,
    output logic                     dir_err
);

    localparam logic [CNT_W:0] TIMEOUT_C = (CNT_W+1)'(TIMEOUT);
    localparam logic [DIR_W:0] NUM_DIR_C = (DIR_W+1)'(NUM_DIR);

    logic             r_sync_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_meas_strobe;
    logic [CNT_W-1:0] r_meas_out;
    logic             r_timeout;
    logic             r_dir_err;

    logic               w_edge;
    logic               w_dir_ok;
    logic               w_accept;
    logic               w_timeout_hit;
    logic               w_cnt_max;
    logic [NUM_DIR-1:0] w_upd;

    assign w_edge        = sync_in & ~r_sync_d;
    assign w_dir_ok      = ({1'b0, dir_in} < NUM_DIR_C);
    assign w_accept      = w_edge & r_armed & w_dir_ok;
    // an edge on the terminal cycle is a valid measurement, so it pre-empts the timeout
    assign w_timeout_hit = r_armed & ~w_edge & ({1'b0, r_cnt} >= TIMEOUT_C);
    assign w_cnt_max     = &r_cnt;

    // Edge detect, interval counter, arming and status pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_d      <= 1'b0;
            r_cnt         <= '0;
            r_armed       <= 1'b0;
            r_meas_strobe <= 1'b0;
            r_meas_out    <= '0;
            r_timeout     <= 1'b0;
            r_dir_err     <= 1'b0;
        end else begin
            r_sync_d      <= sync_in;
            r_meas_strobe <= w_accept;
            r_dir_err     <= w_edge & ~w_dir_ok;
            if (w_accept) begin
                r_meas_out <= r_cnt;
            end
            if (w_edge) begin
                r_cnt     <= CNT_W'(1);
                r_armed   <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_cnt     <= '0;
                r_armed   <= 1'b0;
                r_timeout <= 1'b1;
            end else if (r_armed && !w_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIR; g++) begin : g_ch
        assign w_upd[g] = w_accept && (dir_in == DIR_W'(g));

        spt_channel #(
            .CNT_W       (CNT_W),
            .THRESHOLD   (THRESHOLD),
            .ALPHA_SHIFT (ALPHA_SHIFT),
            .LOCK_COUNT  (LOCK_COUNT)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_upd    (w_upd[g]),
            .i_meas   (r_cnt),
            .i_clear  (w_timeout_hit),
            .o_est    (est_out[g*CNT_W +: CNT_W]),
            .o_valid  (est_valid[g]),
            .o_locked (locked[g])
        );
    end

    assign meas_strobe  = r_meas_strobe;
    assign meas_out     = r_meas_out;
    assign timeout_flag = r_timeout;
    assign dir_err      = r_dir_err;

endmodule

// File: tb/tb_scan_period_tracker.sv
// Bench for scan_period_tracker: a time-stamp based model of the tracking
// rules is compared every cycle, and literal expectations pin key points.
module tb_scan_period_tracker;

    localparam int CNT_W       = 16;
    localparam int NUM_DIR     = 3;
    localparam int THRESHOLD   = 2000;
    localparam int ALPHA_SHIFT = 4;
    localparam int LOCK_COUNT  = 8;
    localparam int TIMEOUT     = 8000;
    localparam int DIR_W       = 2;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     sync_in = 1'b0;
    logic [DIR_W-1:0]         dir_in = '0;
    logic [NUM_DIR*CNT_W-1:0] est_out;
    logic [NUM_DIR-1:0]       est_valid;
    logic [NUM_DIR-1:0]       locked;
    logic                     meas_strobe;
    logic [CNT_W-1:0]         meas_out;
    logic                     timeout_flag;
    logic                     dir_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_period_tracker #(
        .CNT_W       (CNT_W),
        .NUM_DIR     (NUM_DIR),
        .THRESHOLD   (THRESHOLD),
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .LOCK_COUNT  (LOCK_COUNT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_in      (sync_in),
        .dir_in       (dir_in),
        .est_out      (est_out),
        .est_valid    (est_valid),
        .locked       (locked),
        .meas_strobe  (meas_strobe),
        .meas_out     (meas_out),
        .timeout_flag (timeout_flag),
        .dir_err      (dir_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] est_of(input int d);
        return est_out[d*CNT_W +: CNT_W];
    endfunction

    // ---------------- model: edges are time-stamped, intervals are differences
    longint m_est [NUM_DIR];
    bit     m_valid [NUM_DIR];
    int     m_lc [NUM_DIR];
    bit     m_armed, m_prev, m_strobe, m_tof, m_derr;
    longint m_meas, cyc, last_edge;

    initial begin
        cyc = 0; last_edge = 0; m_armed = 0; m_prev = 0;
        m_strobe = 0; m_tof = 0; m_derr = 0; m_meas = 0;
        for (int d = 0; d < NUM_DIR; d++) begin
            m_est[d] = 0; m_valid[d] = 0; m_lc[d] = 0;
        end
    end

    always @(posedge clk) begin
        bit     e;
        longint meas, diff, step, mag;
        int     d;
        if (!reset_n) begin
            m_armed = 0; m_prev = 0; m_strobe = 0; m_tof = 0; m_derr = 0; m_meas = 0;
            for (int k = 0; k < NUM_DIR; k++) begin
                m_est[k] = 0; m_valid[k] = 0; m_lc[k] = 0;
            end
        end else begin
            e = sync_in && !m_prev;
            m_prev = sync_in;
            m_strobe = 0;
            m_derr = 0;
            if (e) begin
                d = int'(dir_in);
                if (d >= NUM_DIR) m_derr = 1;
                if (m_armed && d < NUM_DIR) begin
                    meas = cyc - last_edge;
                    if (meas > (longint'(1) << CNT_W) - 1) meas = (longint'(1) << CNT_W) - 1;
                    m_strobe = 1;
                    m_meas = meas;
                    diff = meas - m_est[d];
                    mag = (diff < 0) ? -diff : diff;
                    if (!m_valid[d] || mag > THRESHOLD) begin
                        m_est[d] = meas; m_valid[d] = 1; m_lc[d] = 0;
                    end else begin
                        step = diff >>> ALPHA_SHIFT;
                        if (step == 0 && diff != 0) step = (diff > 0) ? 1 : -1;
                        m_est[d] = m_est[d] + step;
                        if (m_lc[d] < LOCK_COUNT) m_lc[d]++;
                    end
                end
                m_armed = 1;
                last_edge = cyc;
                m_tof = 0;
            end else if (m_armed && (cyc - last_edge) >= TIMEOUT) begin
                m_armed = 0;
                m_tof = 1;
                for (int k = 0; k < NUM_DIR; k++) begin
                    m_valid[k] = 0; m_lc[k] = 0;
                end
            end
        end
        cyc++;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [NUM_DIR*CNT_W-1:0] e_est;
        logic [NUM_DIR-1:0]       e_val, e_lck;
        for (int k = 0; k < NUM_DIR; k++) begin
            e_est[k*CNT_W +: CNT_W] = CNT_W'(m_est[k]);
            e_val[k] = m_valid[k];
            e_lck[k] = m_valid[k] && (m_lc[k] == LOCK_COUNT);
        end
        chk("cyc_est_out", est_out, e_est);
        chk("cyc_est_valid", est_valid, e_val);
        chk("cyc_locked", locked, e_lck);
        chk("cyc_meas_strobe", meas_strobe, m_strobe);
        chk("cyc_meas_out", meas_out, CNT_W'(m_meas));
        chk("cyc_timeout_flag", timeout_flag, m_tof);
        chk("cyc_dir_err", dir_err, m_derr);
    end

    // Raise a one-cycle sync pulse 'gap' clocks after the previous one
    task automatic edge_at(input int gap, input logic [DIR_W-1:0] dir);
        repeat (gap - 1) @(negedge clk);
        sync_in = 1'b1;
        dir_in  = dir;
        @(negedge clk);
        sync_in = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_est_out", est_out, 0);
        chk("rst_est_valid", est_valid, 0);
        chk("rst_meas_out", meas_out, 0);
        chk("rst_timeout", timeout_flag, 0);
        chk("rst_strobe", meas_strobe, 0);
        reset_n = 1'b1;

        edge_at(20, 2'd0);
        chk("arm_no_strobe", meas_strobe, 0);
        chk("arm_no_valid", est_valid, 0);

        for (int i = 1; i <= 18; i++) begin
            edge_at(1000, DIR_W'(i % 2));
            if (i == 1) begin
                chk("e2_strobe", meas_strobe, 1);
                chk("e2_meas", meas_out, 1000);
                chk("e2_valid", est_valid, 3'b010);
            end
            if (i == 2) chk("e3_valid", est_valid, 3'b011);
            if (i == 16) chk("pre_lock", locked, 3'b000);
        end
        chk("lock_both", locked, 3'b011);
        chk("lock_est0", est_of(0), 1000);
        chk("lock_est1", est_of(1), 1000);

        edge_at(1100, 2'd0);
        chk("smooth_est0", est_of(0), 1006);
        chk("smooth_locked", locked, 3'b011);
        chk("smooth_est1", est_of(1), 1000);

        edge_at(1003, 2'd1);
        chk("minstep_est1", est_of(1), 1001);

        edge_at(7000, 2'd0);
        chk("reload_est0", est_of(0), 7000);
        chk("reload_locked", locked, 3'b010);

        edge_at(900, 2'd1);
        chk("neg_est1", est_of(1), 994);

        edge_at(500, 2'd3);
        chk("bad_dir_err", dir_err, 1);
        chk("bad_dir_strobe", meas_strobe, 0);
        chk("bad_dir_est1", est_of(1), 994);

        edge_at(800, 2'd1);
        chk("after_bad_meas", meas_out, 800);
        chk("after_bad_est1", est_of(1), 981);

        edge_at(TIMEOUT, 2'd2);
        chk("at_timeout_flag", timeout_flag, 0);
        chk("at_timeout_est2", est_of(2), TIMEOUT);
        chk("at_timeout_valid", est_valid, 3'b111);

        repeat (TIMEOUT + 5) @(negedge clk);
        chk("tmo_flag", timeout_flag, 1);
        chk("tmo_valid", est_valid, 0);
        chk("tmo_locked", locked, 0);
        chk("tmo_est0", est_of(0), 7000);
        chk("tmo_est1", est_of(1), 981);

        edge_at(50, 2'd0);
        chk("rearm_flag", timeout_flag, 0);
        chk("rearm_no_strobe", meas_strobe, 0);
        chk("rearm_valid", est_valid, 0);

        edge_at(1234, 2'd0);
        chk("post_tmo_est0", est_of(0), 1234);
        chk("post_tmo_valid", est_valid, 3'b001);

        repeat (300) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_est", est_out, 0);
        chk("mid_rst_meas", meas_out, 0);
        reset_n = 1'b1;
        edge_at(100, 2'd1);
        chk("mid_rst_arm_strobe", meas_strobe, 0);
        edge_at(600, 2'd1);
        chk("mid_rst_est1", est_of(1), 600);
        chk("mid_rst_valid", est_valid, 3'b010);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_period_tracker.md
SCAN_PERIOD_TRACKER -- requirements
Module: scan_period_tracker

Interface
REQ-001 Parameter CNT_W, 32, width of period counter and estimates.
REQ-002 Parameter NUM_DIR, 2, number of scan directions/channels tracked (≥1).
REQ-003 Parameter THRESHOLD, 5000, step-reload window in clocks.
REQ-004 Parameter ALPHA_SHIFT, 4, smoothing shift for in-window updates (0 = load measurement directly).
REQ-005 Parameter LOCK_COUNT, 8, consecutive in-window measurements required for lock.
REQ-006 Parameter TIMEOUT, 2**24, clocks without a sync edge before tracking is abandoned.
REQ-007 Clock clk; reset reset_n, synchronous, active-low.
REQ-008 clk  input  1  100 MHz system clock.
REQ-009 reset_n  input  1  synchronous active-low reset.
REQ-010 sync_in  input  1  scanner sync, already synchronous to clk.
REQ-011 dir_in  input  clog2(NUM_DIR) (min 1)  direction of the scan that begins at this sync edge.
REQ-012 est_out  output  NUM_DIR*CNT_W  per-direction period estimate, channel d at bits [d*CNT_W +: CNT_W].
REQ-013 est_valid  output  NUM_DIR  estimate d holds at least one measurement since reset/timeout.
REQ-014 locked  output  NUM_DIR  channel d has met LOCK_COUNT.
REQ-015 meas_strobe  output  1  one-cycle pulse when any measurement is accepted.
REQ-016 meas_out  output  CNT_W  last accepted measurement.
REQ-017 timeout_flag  output  1  high while tracking is abandoned; cleared by next sync edge.
REQ-018 dir_err  output  1  one-cycle pulse when dir_in ≥ NUM_DIR at a sync edge.

Function
REQ-019 Rising edge = sync_in high while a one-cycle registered copy is low; all updates occur on that cycle and are visible the next cycle (latency 1).
REQ-020 Free-running interval counter counts clocks since last edge, saturates at all-ones, reloads to 1 on each edge.
REQ-021 Measurement = interval counter value on the edge cycle, charged to the channel given by dir_in sampled on that same cycle.
REQ-022 First edge after reset or timeout only arms the counter; no measurement, no strobe.
REQ-023 Per-channel states: EMPTY, ACQUIRE, TRACK, LOCK; reset/timeout -> EMPTY.
REQ-024 EMPTY + measurement: est = meas, est_valid=1, lock count=0 -> ACQUIRE.
REQ-025 Any non-EMPTY state, |meas-est| > THRESHOLD (computed CNT_W+1 bits, no wrap): est = meas, lock count=0, locked=0 -> ACQUIRE.
REQ-026 In-window: diff = meas-est signed; est += diff >>> ALPHA_SHIFT, with minimum step ±1 when diff≠0 and shifted result is 0; diff=0 leaves est.
REQ-027 In-window: lock count increments (saturating at LOCK_COUNT); ACQUIRE -> TRACK; reaching LOCK_COUNT -> LOCK with locked=1.
REQ-028 Only the addressed channel changes; other channels hold.
REQ-029 dir_in ≥ NUM_DIR: dir_err pulses, no channel updates, counter still reloads.
REQ-030 Counter reaching TIMEOUT with no edge: all channels -> EMPTY, est_valid=0, locked=0, est_out held, timeout_flag=1.
REQ-031 Edge on same cycle counter reaches TIMEOUT: edge wins, measurement processed, no timeout.
REQ-032 meas_strobe and meas_out update for every accepted measurement, including reloads.

Reset
REQ-033 Reset: est_out=0, est_valid=0, locked=0, meas_strobe=0, meas_out=0, timeout_flag=0, dir_err=0, counter=0, disarmed, edge register=0.
REQ-034 Reset asserted mid-interval discards partial interval; first edge after release only arms.

Structure
REQ-035 Package spt_pkg holds channel state enum and default parameter constants.
REQ-036 Sub-module spt_channel (one per direction, generate loop) holds estimate, state, lock count; top holds edge detect, counter, timeout, decode.

Verification
REQ-037 Reset, edges every 1000 clocks, dir alternating 0/1 -> first edge no strobe; est0=est1=1000, valid after 2nd/3rd edges; locked after LOCK_COUNT further edges each.
REQ-038 Locked at 1000, next dir0 interval 1100 (ALPHA_SHIFT=4) -> est0=1006, locked stays 1, est1 unchanged.
REQ-039 Locked at 1000, dir0 interval 7000 -> est0=7000, locked0=0, state ACQUIRE.
REQ-040 Locked at 1000, diff +3 (ALPHA_SHIFT=4) -> est0=1001 (minimum step).
REQ-041 TIMEOUT=5000, no edge for 5000 clocks -> timeout_flag=1, valid/locked=0, est held; next edge arms only, following edge reloads.
REQ-042 NUM_DIR=3, dir_in=3 -> dir_err pulse, no est change; next interval measured from that edge.
